// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM demux/accumulate path.
package tdm_pkg;

  typedef enum logic {IDLE, RUN} tdm_state_t;

  // Width of a channel (or counter) index; never narrower than 1 bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [63:0] sat_max(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/tdm_demux_acc_sat_add.sv
// Combinational unsigned saturating adder with overflow flag.
module sat_add
  import tdm_pkg::*;
#(
  parameter int A_W = 20,
  parameter int B_W = 16,
  parameter int S_W = 20
) (
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  output logic [S_W-1:0] sum_o,
  output logic           ovf_o
);

  localparam int FW = ((A_W > B_W) ? A_W : B_W) + 1;

  logic [FW-1:0] full;

  assign full  = {{(FW-A_W){1'b0}}, a_i} + {{(FW-B_W){1'b0}}, b_i};
  assign ovf_o = |full[FW-1:S_W];
  assign sum_o = ovf_o ? S_W'(sat_max(S_W)) : full[S_W-1:0];

endmodule

// File: rtl/tdm_demux_acc.sv
// De-interleaves a round-robin TDM sample stream and emits saturating per-channel frame sums.
//   state | meaning
//   IDLE  | waiting for a channel-0 sample to align on
//   RUN   | aligned; each sample must carry the expected channel tag
module tdm_demux_acc
  import tdm_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 2,
  parameter int FRAME_LEN  = 4,
  parameter int ACC_WIDTH  = 20,
  localparam int CH_W      = ch_w(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic [CH_W-1:0]       din_chan,
  output logic [ACC_WIDTH-1:0]  dout,
  output logic                  dout_valid,
  output logic [CH_W-1:0]       dout_chan,
  output logic                  dout_sat,
  output logic                  seq_err
);

  localparam int               CNT_W    = ch_w(FRAME_LEN);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  tdm_state_t           state_q, state_d;
  logic [CH_W-1:0]      exp_q, exp_d;
  logic                 seq_err_q, seq_err_d;
  logic [ACC_WIDTH-1:0] acc_q [NUM_CH];
  logic [ACC_WIDTH-1:0] acc_d [NUM_CH];
  logic [CNT_W-1:0]     cnt_q [NUM_CH];
  logic [CNT_W-1:0]     cnt_d [NUM_CH];
  logic                 sat_q [NUM_CH];
  logic                 sat_d [NUM_CH];
  logic [ACC_WIDTH-1:0] dout_q, dout_d;
  logic                 dvalid_q, dvalid_d;
  logic [CH_W-1:0]      dchan_q, dchan_d;
  logic                 dsat_q, dsat_d;

  logic                 chan_ok, chan_match, accept, mismatch;
  logic [CH_W-1:0]      sel;
  logic [ACC_WIDTH-1:0] sum;
  logic                 ovf;

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    return (c == LAST_CH) ? '0 : c + CH_W'(1);
  endfunction

  // Out-of-range tags (non-power-of-2 NUM_CH) never index the arrays.
  assign chan_ok    = 32'(din_chan) < NUM_CH;
  assign sel        = chan_ok ? din_chan : '0;
  assign chan_match = chan_ok && ((state_q == IDLE) ? (din_chan == '0) : (din_chan == exp_q));
  assign accept     = din_valid && !clear && chan_match;
  assign mismatch   = din_valid && !clear && (state_q == RUN) && !chan_match;

  // One adder shared across channels, fed by the tagged channel's accumulator.
  sat_add #(
    .A_W(ACC_WIDTH),
    .B_W(DATA_WIDTH),
    .S_W(ACC_WIDTH)
  ) u_sat_add (
    .a_i  (acc_q[sel]),
    .b_i  (din),
    .sum_o(sum),
    .ovf_o(ovf)
  );

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    seq_err_d = seq_err_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    dout_d    = dout_q;
    dchan_d   = dchan_q;
    dsat_d    = dsat_q;
    dvalid_d  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      exp_d   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_d[c] = '0;
        cnt_d[c] = '0;
        sat_d[c] = 1'b0;
      end
    end else if (accept) begin
      state_d = RUN;
      exp_d   = next_ch(sel);
      if (cnt_q[sel] == LAST_CNT) begin
        dout_d     = sum;
        dchan_d    = sel;
        dsat_d     = sat_q[sel] | ovf;
        dvalid_d   = 1'b1;
        acc_d[sel] = '0;
        cnt_d[sel] = '0;
        sat_d[sel] = 1'b0;
      end else begin
        acc_d[sel] = sum;
        cnt_d[sel] = cnt_q[sel] + CNT_W'(1);
        sat_d[sel] = sat_q[sel] | ovf;
      end
    end else if (mismatch) begin
      seq_err_d = 1'b1;
      exp_d     = chan_ok ? next_ch(din_chan) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      exp_q     <= '0;
      seq_err_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
        sat_q[c] <= 1'b0;
      end
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      dchan_q  <= '0;
      dsat_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      seq_err_q <= seq_err_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      dout_q    <= dout_d;
      dvalid_q  <= dvalid_d;
      dchan_q   <= dchan_d;
      dsat_q    <= dsat_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dvalid_q;
  assign dout_chan  = dchan_q;
  assign dout_sat   = dsat_q;
  assign seq_err    = seq_err_q;

endmodule
